// File: rtl/imem_boot_loader.sv
// imem_boot_loader: boot stage for the single-cycle MIPS core.
// Accepts a byte stream (16-bit big-endian word count, then 4 bytes per
// big-endian word), writes each assembled word into instruction memory and
// keeps the core in reset until the whole image is in. A count larger than
// the instruction memory latches an error and keeps the core in reset.
// Instruction memory lives outside this block; a reset here never clears it.
module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  // Word index width: one index per 4-byte word of the byte-addressed memory.
  localparam int          IDX_W     = ADDR_W - 2;
  localparam logic [16:0] MAX_CNT   = 17'(MAX_WORDS);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_CHECK,
    S_DATA,
    S_WRITE,
    S_RUN,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q;
  logic [IDX_W-1:0]  word_idx_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_q;       // first three bytes of the word being built
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic xfer;
  logic last_word;

  assign xfer      = in_valid & in_ready;
  assign last_word = ({{(16-IDX_W){1'b0}}, word_idx_q} == (cnt_q - 16'd1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register in the
    // design updates from the same pre-edge values, independent of block order.
    if (reset) begin
      state_q <= S_CNT_HI;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: header bytes, size check, data bytes, one write cycle.
  always_comb begin
    // NOTE: state_d gets a default before the case so every path assigns it
    // and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_CNT_HI: if (xfer) state_d = S_CNT_LO;
      S_CNT_LO: if (xfer) state_d = S_CHECK;
      S_CHECK: begin
        if (cnt_q == 16'd0)               state_d = S_RUN;
        else if ({1'b0, cnt_q} > MAX_CNT) state_d = S_ERR;
        else                              state_d = S_DATA;
      end
      S_DATA:  if (xfer && byte_idx_q == 2'd3) state_d = S_WRITE;
      S_WRITE: state_d = last_word ? S_RUN : S_DATA;
      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_CNT_HI;
    endcase
  end

  // Datapath: capture count, pack bytes, issue the registered write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      // The strobe is a single-cycle pulse; address and data hold afterwards.
      we_q <= 1'b0;
      case (state_q)
        S_CNT_HI: if (xfer) cnt_q[15:8] <= in_data;
        S_CNT_LO: if (xfer) cnt_q[7:0]  <= in_data;
        S_DATA: begin
          if (xfer) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              we_q    <= 1'b1;
              addr_q  <= {word_idx_q, 2'b00};
              wdata_q <= {word_q, in_data};
            end else begin
              word_q <= {word_q[15:0], in_data};
            end
          end
        end
        S_WRITE: begin
          byte_idx_q <= '0;
          if (!last_word) word_idx_q <= word_idx_q + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

  // Output decode: handshake and core-control flags from the current state.
  always_comb begin
    in_ready  = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state_q)
      S_CNT_HI, S_CNT_LO, S_DATA: in_ready = ~reset;
      S_RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: normal load, empty image, oversize
// header, full-size image, gapped stream and reset in the middle of a load.
module tb_imem_boot_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int last_xfer_cyc = 0;

  // Write log, filled only by the monitor.
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cyc   = -1;
  int          excl_viol  = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor sampled mid-cycle.
  initial begin
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        wr_addr.push_back(32'(imem_addr));
        wr_data.push_back(imem_wdata);
        wr_cyc.push_back(cyc);
      end
      if (done === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
      done_prev = done;
      if (done === 1'b1 && error === 1'b1) excl_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done",      32'(done),      32'd0);
    check("rst_error",     32'(error),     32'd0);
    check("rst_we",        32'(imem_we),   32'd0);
    check("rst_addr",      32'(imem_addr), 32'd0);
    check("rst_wdata",     imem_wdata,     32'd0);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      last_xfer_cyc = cyc;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int base;
    int bad;
    int k;
    logic [7:0] img1[8];

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bad;
    int last;
    logic [7:0] img1[8];

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    img1 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};

    // Two-word image.
    reset_dut();
    @(negedge clk);
    check("t1_ready_after_rst", 32'(in_ready), 32'd1);
    base = wr_addr.size();
    send_byte(8'h00);
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) begin
      send_byte(img1[i]);
      if (i == 3) begin
        @(negedge clk);
        check("t1_w0_latency", 32'(wr_cyc.size() > base ? wr_cyc[base] : -1), 32'(last_xfer_cyc));
      end
    end
    wait_done("t1_done", 20);
    check("t1_nwrites",  32'(wr_addr.size() - base), 32'd2);
    if (wr_addr.size() - base == 2) begin
      check("t1_addr0", wr_addr[base],     32'h0);
      check("t1_data0", wr_data[base],     32'h20080005);
      check("t1_addr1", wr_addr[base + 1], 32'h4);
      check("t1_data1", wr_data[base + 1], 32'h01095020);
      check("t1_w1_latency", 32'(wr_cyc[base + 1]), 32'(last_xfer_cyc));
      check("t1_done_latency", 32'(done_cyc), 32'(wr_cyc[base + 1] + 1));
    end
    check("t1_cpu_reset", 32'(cpu_reset), 32'd0);
    check("t1_error",     32'(error),     32'd0);
    check("t1_ready_run", 32'(in_ready),  32'd0);
    check("t1_we_low",    32'(imem_we),   32'd0);
    check("t1_addr_hold", 32'(imem_addr), 32'h4);
    check("t1_data_hold", imem_wdata,     32'h01095020);

    // Empty image.
    reset_dut();
    base = wr_addr.size();
    send_byte(8'h00);
    send_byte(8'h00);
    wait_done("t2_done", 10);
    check("t2_done_latency", 32'(done_cyc), 32'(last_xfer_cyc + 1));
    check("t2_nwrites",  32'(wr_addr.size() - base), 32'd0);
    check("t2_cpu_reset", 32'(cpu_reset), 32'd0);

    // Oversize image: 257 words.
    reset_dut();
    base = wr_addr.size();
    send_byte(8'h01);
    send_byte(8'h01);
    repeat (3) @(negedge clk);
    check("t3_error",     32'(error),     32'd1);
    check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t3_done",      32'(done),      32'd0);
    check("t3_ready",     32'(in_ready),  32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) @(negedge clk);
    check("t3_ready_offer", 32'(in_ready), 32'd0);
    check("t3_error_hold",  32'(error),    32'd1);
    in_valid = 1'b0;
    check("t3_nwrites", 32'(wr_addr.size() - base), 32'd0);

    // Full-size image, word k = k.
    reset_dut();
    base = wr_addr.size();
    send_byte(8'h01);
    send_byte(8'h00);
    for (int w = 0; w < MAX_WORDS; w++) begin
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'(w));
    end
    wait_done("t4_done", 20);
    check("t4_nwrites", 32'(wr_addr.size() - base), 32'd256);
    if (wr_addr.size() - base == 256) begin
      last = base + 255;
      check("t4_last_addr", wr_addr[last], 32'h3FC);
      check("t4_last_data", wr_data[last], 32'h000000FF);
      check("t4_done_latency", 32'(done_cyc), 32'(wr_cyc[last] + 1));
      bad = 0;
      for (int w = 0; w < 256; w++) begin
        if (wr_addr[base + w] !== 32'(w * 4) || wr_data[base + w] !== 32'(w)) bad++;
      end
      check("t4_all_words_bad", 32'(bad), 32'd0);
    end

    // One word with random gaps between bytes.
    reset_dut();
    base = wr_addr.size();
    send_byte(8'h00);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    send_byte(8'h01);
    send_byte(8'h12);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    send_byte(8'h34);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    send_byte(8'h56);
    repeat ($urandom_range(1, 3)) @(negedge clk);
    send_byte(8'h78);
    wait_done("t5_done", 10);
    check("t5_nwrites", 32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() - base == 1) begin
      check("t5_addr", wr_addr[base], 32'h0);
      check("t5_data", wr_data[base], 32'h12345678);
      check("t5_latency", 32'(wr_cyc[base]), 32'(last_xfer_cyc));
    end

    // Reset after two data bytes, then a clean one-word image.
    reset_dut();
    base = wr_addr.size();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hBE;
    #1;
    check("t6_ready_in_rst", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("t6_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t6_done",      32'(done),      32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    wait_done("t6_done_final", 10);
    check("t6_nwrites", 32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() - base == 1) begin
      check("t6_addr", wr_addr[base], 32'h0);
      check("t6_data", wr_data[base], 32'hAABBCCDD);
    end

    check("done_error_excl", 32'(excl_viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
